// File: rtl/gte_instr_sequencer_pkg.sv
// Shared types, opcode constants and microcode generation for the GTE instruction sequencer.
// The ROM image is produced at elaboration by ucode_word(), so no external memory file is needed.
package gte_instr_sequencer_pkg;

    localparam int CMD_W = 25;

    // Latched instruction parameters; bit order sf, mx, vec, cv, lm.
    typedef struct packed {
        logic       sf;
        logic [1:0] mx;
        logic [1:0] vec;
        logic [1:0] cv;
        logic       lm;
    } CTRL;

    typedef struct packed {
        logic       mac_en;
        logic       ir_en;
        logic       div_en;
        logic [5:0] step;
    } gteComputeCtrl;

    typedef struct packed {
        logic       we;
        logic [5:0] reg_addr;
        logic       chk_flags;
    } gteWriteBack;

    typedef struct packed {
        logic          last;
        gteWriteBack   wb;
        gteComputeCtrl ctrl;
    } gteMicroOp;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_e;

    localparam logic [5:0] OP_RTPS  = 6'h01;
    localparam logic [5:0] OP_NCLIP = 6'h06;
    localparam logic [5:0] OP_OP    = 6'h0C;
    localparam logic [5:0] OP_DPCS  = 6'h10;
    localparam logic [5:0] OP_INTPL = 6'h11;
    localparam logic [5:0] OP_MVMVA = 6'h12;
    localparam logic [5:0] OP_NCDS  = 6'h13;
    localparam logic [5:0] OP_CDP   = 6'h14;
    localparam logic [5:0] OP_NCDT  = 6'h16;
    localparam logic [5:0] OP_NCCS  = 6'h1B;
    localparam logic [5:0] OP_CC    = 6'h1C;
    localparam logic [5:0] OP_NCS   = 6'h1E;
    localparam logic [5:0] OP_NCT   = 6'h20;
    localparam logic [5:0] OP_SQR   = 6'h28;
    localparam logic [5:0] OP_DCPL  = 6'h29;
    localparam logic [5:0] OP_DPCT  = 6'h2A;
    localparam logic [5:0] OP_AVSZ3 = 6'h2D;
    localparam logic [5:0] OP_AVSZ4 = 6'h2E;
    localparam logic [5:0] OP_RTPT  = 6'h30;
    localparam logic [5:0] OP_GPF   = 6'h3D;
    localparam logic [5:0] OP_GPL   = 6'h3E;
    localparam logic [5:0] OP_NCCT  = 6'h3F;

    // Physical ROM regions. Single-vector forms (RTPS, NCDS, NCCS, NCS, DPCS) enter
    // their triple-vector region part-way through and share its tail.
    // Region order: RTPT NCDT NCCT NCT DPCT NCLIP OP INTPL MVMVA CDP CC SQR DCPL AVSZ3 AVSZ4 GPF GPL
    localparam int NUM_SEQ    = 17;
    localparam int UCODE_USED = 207;
    localparam int SEQ_START [NUM_SEQ] = '{0, 21, 63, 100, 128, 143, 149, 153, 159,
                                           165, 176, 185, 188, 194, 197, 201, 204};
    localparam int SEQ_LEN   [NUM_SEQ] = '{21, 42, 37, 28, 15, 6, 4, 6, 6,
                                           11, 9, 3, 6, 3, 4, 3, 3};
    localparam logic [5:0] SEQ_DEST [NUM_SEQ] = '{6'd14, 6'd22, 6'd22, 6'd22, 6'd22, 6'd24,
                                                  6'd25, 6'd22, 6'd25, 6'd22, 6'd22, 6'd25,
                                                  6'd22, 6'd7, 6'd7, 6'd22, 6'd22};

    // Sequences longer than three ops drain the pipeline with one NOP before the
    // final op, which commits the result and checks flags.
    function automatic gteMicroOp ucode_word(input int addr);
        gteMicroOp w;
        int        idx;
        w   = '0;
        idx = 0;
        for (int s = 0; s < NUM_SEQ; s++) begin
            if (addr >= SEQ_START[s] && addr < SEQ_START[s] + SEQ_LEN[s]) begin
                idx = addr - SEQ_START[s];
                if (idx == SEQ_LEN[s] - 1) begin
                    w.last          = 1'b1;
                    w.ctrl.ir_en    = 1'b1;
                    w.ctrl.step     = 6'(idx);
                    w.wb.we         = 1'b1;
                    w.wb.reg_addr   = SEQ_DEST[s];
                    w.wb.chk_flags  = 1'b1;
                end else if (!(SEQ_LEN[s] > 3 && idx == SEQ_LEN[s] - 2)) begin
                    w.ctrl.mac_en = 1'b1;
                    w.ctrl.div_en = (s == 0);
                    w.ctrl.step   = 6'(idx);
                end
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/gte_instr_sequencer_ucode_rom.sv
// Micro-op ROM with 1-cycle registered read, plus the opcode -> {valid, startAddr} table.
module gte_instr_sequencer_ucode_rom
    import gte_instr_sequencer_pkg::*;
#(
    parameter int UCODE_DEPTH = 256,
    localparam int AW = $clog2(UCODE_DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_nRst,
    input  logic [5:0]    i_op,
    output logic          o_opValid,
    output logic [AW-1:0] o_startAddr,
    input  logic [AW-1:0] i_addr,
    output gteMicroOp     o_uop
);

    gteMicroOp w_rom [UCODE_DEPTH];
    gteMicroOp r_uop;

    for (genvar a = 0; a < UCODE_DEPTH; a++) begin : g_rom
        assign w_rom[a] = ucode_word(a);
    end

    always_comb begin
        o_opValid   = 1'b1;
        o_startAddr = '0;
        case (i_op)
            OP_RTPT:  o_startAddr = AW'(0);
            OP_RTPS:  o_startAddr = AW'(8);
            OP_NCDT:  o_startAddr = AW'(21);
            OP_NCDS:  o_startAddr = AW'(46);
            OP_NCCT:  o_startAddr = AW'(63);
            OP_NCCS:  o_startAddr = AW'(85);
            OP_NCT:   o_startAddr = AW'(100);
            OP_NCS:   o_startAddr = AW'(116);
            OP_DPCT:  o_startAddr = AW'(128);
            OP_DPCS:  o_startAddr = AW'(137);
            OP_NCLIP: o_startAddr = AW'(143);
            OP_OP:    o_startAddr = AW'(149);
            OP_INTPL: o_startAddr = AW'(153);
            OP_MVMVA: o_startAddr = AW'(159);
            OP_CDP:   o_startAddr = AW'(165);
            OP_CC:    o_startAddr = AW'(176);
            OP_SQR:   o_startAddr = AW'(185);
            OP_DCPL:  o_startAddr = AW'(188);
            OP_AVSZ3: o_startAddr = AW'(194);
            OP_AVSZ4: o_startAddr = AW'(197);
            OP_GPF:   o_startAddr = AW'(201);
            OP_GPL:   o_startAddr = AW'(204);
            default:  o_opValid   = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_uop <= '0;
        end else begin
            r_uop <= w_rom[i_addr];
        end
    end

    assign o_uop = r_uop;

endmodule

// File: rtl/gte_instr_sequencer.sv
// GTE microcode sequencer: accepts one COP2 command, then drives one compute-control and one
// write-back word per cycle so each instruction takes exactly its PSX cycle count.
module gte_instr_sequencer
    import gte_instr_sequencer_pkg::*;
#(
    parameter int UCODE_DEPTH = 256
) (
    input  logic             i_clk,
    input  logic             i_nRst,
    input  logic             i_cmdValid,
    input  logic [CMD_W-1:0] i_cmd,
    output logic             o_cmdReady,
    output logic             o_busy,
    output CTRL              o_instrParam,
    output logic             o_isMVMVA,
    output gteComputeCtrl    o_computeCtrl,
    output gteWriteBack      o_wb,
    output logic             o_clearFlags,
    output logic             o_updateFlag31,
    output logic             o_done,
    output logic             o_illegal
);

    localparam int AW = $clog2(UCODE_DEPTH);

    seq_state_e    r_state;
    seq_state_e    w_nextState;
    logic [5:0]    r_op;
    CTRL           r_param;
    logic          r_isMVMVA;
    logic          r_illegalPending;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_romAddr;
    logic [AW-1:0] w_startAddr;
    logic          w_opValid;
    gteMicroOp     w_uop;
    logic          w_ready;
    logic          w_accept;
    logic          w_unusedCmdBits;

    // Handshake: a command transfers on a cycle where i_cmdValid and o_cmdReady are both
    // high. Ready is only offered in IDLE and FINISH and is held low while reset is asserted.
    assign w_ready         = i_nRst & ((r_state == ST_IDLE) || (r_state == ST_FINISH));
    assign w_accept        = i_cmdValid & w_ready;
    assign w_unusedCmdBits = ^{i_cmd[24:20], i_cmd[12:11], i_cmd[9:6]};

    gte_instr_sequencer_ucode_rom #(
        .UCODE_DEPTH(UCODE_DEPTH)
    ) u_rom (
        .i_clk       (i_clk),
        .i_nRst      (i_nRst),
        .i_op        (r_op),
        .o_opValid   (w_opValid),
        .o_startAddr (w_startAddr),
        .i_addr      (w_romAddr),
        .o_uop       (w_uop)
    );

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_state          <= ST_IDLE;
            r_op             <= '0;
            r_param          <= '0;
            r_isMVMVA        <= 1'b0;
            r_illegalPending <= 1'b0;
            r_addr           <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_op             <= i_cmd[5:0];
                r_param          <= '{sf: i_cmd[19], mx: i_cmd[18:17], vec: i_cmd[16:15],
                                      cv: i_cmd[14:13], lm: i_cmd[10]};
                r_isMVMVA        <= (i_cmd[5:0] == OP_MVMVA);
                r_illegalPending <= 1'b0;
            end else if (r_state == ST_DECODE) begin
                r_illegalPending <= ~w_opValid;
            end
            // DECODE reads startAddr directly, so the counter resumes one past it.
            if (r_state == ST_DECODE) begin
                r_addr <= w_startAddr + AW'(1);
            end else if (r_state == ST_RUN) begin
                r_addr <= r_addr + AW'(1);
            end
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_romAddr      = r_addr;
        o_clearFlags   = 1'b0;
        o_done         = 1'b0;
        o_updateFlag31 = 1'b0;
        o_illegal      = 1'b0;
        o_computeCtrl  = '0;
        o_wb           = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_nextState = ST_DECODE;
                end
            end
            ST_DECODE: begin
                o_clearFlags = 1'b1;
                w_romAddr    = w_startAddr;
                w_nextState  = w_opValid ? ST_RUN : ST_FINISH;
            end
            ST_RUN: begin
                o_computeCtrl = w_uop.ctrl;
                o_wb          = w_uop.wb;
                if (w_uop.last) begin
                    w_nextState = ST_FINISH;
                end
            end
            ST_FINISH: begin
                o_done         = 1'b1;
                o_updateFlag31 = 1'b1;
                o_illegal      = r_illegalPending;
                w_nextState    = w_accept ? ST_DECODE : ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    assign o_cmdReady   = w_ready;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_instrParam = r_param;
    assign o_isMVMVA    = r_isMVMVA;

endmodule

// File: tb/tb_gte_instr_sequencer.sv
// Directed bench for gte_instr_sequencer: a driver issues commands and queues the expected
// completion; a negedge monitor checks every o_done against that queue.
module tb_gte_instr_sequencer;
    import gte_instr_sequencer_pkg::*;

    typedef struct {
        int         done_cyc;
        logic       illegal;
        logic [7:0] param;
        logic       is_mvmva;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [24:0]   cmd_word = '0;
    logic          o_cmdReady, o_busy, o_isMVMVA, o_clearFlags, o_updateFlag31, o_done, o_illegal;
    CTRL           o_instrParam;
    gteComputeCtrl o_computeCtrl;
    gteWriteBack   o_wb;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    gte_instr_sequencer dut (
        .i_clk          (clk),
        .i_nRst         (rst_n),
        .i_cmdValid     (cmd_valid),
        .i_cmd          (cmd_word),
        .o_cmdReady     (o_cmdReady),
        .o_busy         (o_busy),
        .o_instrParam   (o_instrParam),
        .o_isMVMVA      (o_isMVMVA),
        .o_computeCtrl  (o_computeCtrl),
        .o_wb           (o_wb),
        .o_clearFlags   (o_clearFlags),
        .o_updateFlag31 (o_updateFlag31),
        .o_done         (o_done),
        .o_illegal      (o_illegal)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] param_of(input logic [24:0] c);
        return {c[19], c[18:17], c[16:15], c[14:13], c[10]};
    endfunction

    // Called at a negedge. Returns t = accept cycle; the DUT leaves DECODE visible at t+1.
    task automatic present(input logic [24:0] c, input int n, input logic ill, input bit hold,
                           output int t);
        int waited;
        waited    = 0;
        cmd_word  = c;
        cmd_valid = 1'b1;
        while (!o_cmdReady && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        t = cyc;
        if (!o_cmdReady) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ready stayed 0 for op %0h, required 1", c[5:0]);
            cmd_valid = 1'b0;
        end else begin
            exp_q.push_back('{done_cyc: cyc + n, illegal: ill, param: param_of(c),
                              is_mvmva: (c[5:0] == 6'h12)});
            @(posedge clk);
            #1;
            if (!hold) cmd_valid = 1'b0;
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && o_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done at cycle %0d, required none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
                check("illegal", o_illegal, mon_e.illegal);
                check("update_flag31", o_updateFlag31, 1'b1);
                check("instr_param", o_instrParam, mon_e.param);
                check("is_mvmva", o_isMVMVA, mon_e.is_mvmva);
                check("finish_ctrl_wb_zero", {o_computeCtrl, o_wb}, 0);
            end
        end else if (rst_n && o_illegal) begin
            checks++;
            errors++;
            $display("FAIL illegal_without_done: illegal=1 done=0, required illegal only with done");
        end
    end

    logic [5:0] tbl_op [8] = '{6'h01, 6'h0C, 6'h10, 6'h1B, 6'h3F, 6'h2B, 6'h3C, 6'h13};
    int         tbl_n  [8] = '{15, 6, 8, 17, 39, 2, 2, 19};

    initial begin
        int t;
        int t2;
        int nz;
        int guard;
        logic [24:0] c;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ready", o_cmdReady, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_outputs", {o_done, o_illegal, o_clearFlags, o_updateFlag31, o_isMVMVA,
                              o_instrParam, o_computeCtrl, o_wb}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", o_cmdReady, 1'b1);

        // SQR sf=1: N=5
        present(25'h28 | (25'h1 << 19), 5, 1'b0, 1'b0, t);
        nz = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("sqr_busy_%0d", k), o_busy, 1'b1);
            check($sformatf("sqr_clear_flags_%0d", k), o_clearFlags, (k == 1));
            if (k == 1) check("sqr_param_sf", o_instrParam.sf, 1'b1);
            if (k >= 2 && k <= 4 && o_computeCtrl != '0) nz++;
        end
        check("sqr_nonzero_ctrl_cycles", 64'(nz), 64'd3);
        @(negedge clk);
        check("sqr_idle_after", o_busy, 1'b0);

        // RTPT with valid held: ready low T+1..T+22, done at T+23
        present(25'h30, 23, 1'b0, 1'b1, t);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            check($sformatf("rtpt_ready_low_%0d", k), o_cmdReady, 1'b0);
        end
        @(negedge clk);
        check("rtpt_ready_at_finish", o_cmdReady, 1'b1);
        cmd_valid = 1'b0;
        @(negedge clk);

        // back-to-back GPF -> AVSZ4
        present(25'h3D, 5, 1'b0, 1'b0, t);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("b2b_busy_%0d", k), o_busy, 1'b1);
        end
        present(25'h2E, 6, 1'b0, 1'b0, t2);
        check("b2b_second_accept", 64'(t2 - t), 64'd5);
        for (int k = 6; k <= 11; k++) begin
            @(negedge clk);
            check($sformatf("b2b_busy_%0d", k), o_busy, 1'b1);
        end
        @(negedge clk);
        check("b2b_idle_after", o_busy, 1'b0);

        // illegal opcode 0x00: N=2
        present(25'h0, 2, 1'b1, 1'b0, t);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            check($sformatf("ill_busy_%0d", k), o_busy, 1'b1);
            check($sformatf("ill_ctrl_wb_zero_%0d", k), {o_computeCtrl, o_wb}, 0);
        end
        @(negedge clk);
        check("ill_idle_after", o_busy, 1'b0);

        // MVMVA mx=2 vec=1 cv=3 lm=1
        c = 25'h12 | (25'h1 << 10) | (25'h3 << 13) | (25'h1 << 15) | (25'h2 << 17);
        present(c, 8, 1'b0, 1'b0, t);
        @(negedge clk);
        check("mvmva_flag", o_isMVMVA, 1'b1);
        check("mvmva_param", o_instrParam, 8'h4F);
        repeat (8) @(negedge clk);
        check("mvmva_idle_after", o_busy, 1'b0);

        // reset at cycle 20 of NCDT, then NCLIP
        present(25'h16 | (25'h1 << 19) | (25'h1 << 10), 44, 1'b0, 1'b0, t);
        while (cyc < t + 20) @(negedge clk);
        check("ncdt_busy_before_reset", o_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", o_busy, 1'b0);
        check("midrst_ready", o_cmdReady, 1'b0);
        check("midrst_outputs", {o_done, o_illegal, o_clearFlags, o_updateFlag31, o_isMVMVA,
                                 o_instrParam, o_computeCtrl, o_wb}, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_release_ready", o_cmdReady, 1'b1);
        @(negedge clk);
        present(25'h06, 8, 1'b0, 1'b0, t);
        repeat (9) @(negedge clk);
        check("nclip_idle_after", o_busy, 1'b0);

        // table of further opcodes, legal and illegal
        for (int i = 0; i < 8; i++) begin
            c = 25'(tbl_op[i]);
            c[19] = i[0];
            c[14:13] = i[1:0];
            present(c, tbl_n[i], (tbl_n[i] == 2), 1'b0, t);
            guard = 0;
            while (exp_q.size() > 0 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (exp_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: op %0h never completed, required done", tbl_op[i]);
                exp_q.delete();
            end
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
